// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of {pc, instr}
// pairs with wrap-bit pointers and a flush that discards everything buffered.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [PC_W-1:0]            enq_pc,
   input  logic [INSTR_W-1:0]         enq_instr,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [PC_W-1:0]            deq_pc,
   output logic [INSTR_W-1:0]         deq_instr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW-1:0]      wr_ptr_r;
   logic [PW-1:0]      rd_ptr_r;
   logic [PC_W-1:0]    pc_mem_r    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_r [DEPTH];

   logic empty_s;
   logic full_s;
   logic enq_fire_s;
   logic deq_fire_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                    (wr_ptr_r[AW] != rd_ptr_r[AW]);

   // Flush suppresses both handshakes; the head consumed in that cycle is not retired.
   assign enq_fire_s = enq_valid && !full_s && !flush;
   assign deq_fire_s = deq_ready && !empty_s && !flush;

   // Pointer registers: flush collapses the read pointer onto the write pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         rd_ptr_r <= wr_ptr_r;
      end else begin
         if (enq_fire_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (deq_fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Entry storage: written on an accepted enqueue, never reset.
   always_ff @(posedge clk) begin
      if (enq_fire_s) begin
         pc_mem_r[wr_ptr_r[AW-1:0]]    <= enq_pc;
         instr_mem_r[wr_ptr_r[AW-1:0]] <= enq_instr;
      end
   end

   // Head presentation: zeroed when empty so stale storage never leaks out.
   always_comb begin
      deq_pc    = '0;
      deq_instr = '0;
      if (!empty_s) begin
         deq_pc    = pc_mem_r[rd_ptr_r[AW-1:0]];
         deq_instr = instr_mem_r[rd_ptr_r[AW-1:0]];
      end else begin
         deq_pc    = '0;
         deq_instr = '0;
      end
   end

   assign count     = wr_ptr_r - rd_ptr_r;
   assign full      = full_s;
   assign empty     = empty_s;
   assign enq_ready = !full_s;
   assign deq_valid = !empty_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4): fill, drain, streaming
// across pointer wraps, flush, full-with-dequeue and asynchronous reset.
module tb_fetch_queue;

   localparam int DEPTH   = 4;
   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   logic                  clk;
   logic                  rst;
   logic                  flush;
   logic                  enq_valid;
   logic                  enq_ready;
   logic [PC_W-1:0]       enq_pc;
   logic [INSTR_W-1:0]    enq_instr;
   logic                  deq_valid;
   logic                  deq_ready;
   logic [PC_W-1:0]       deq_pc;
   logic [INSTR_W-1:0]    deq_instr;
   logic [$clog2(DEPTH):0] count;
   logic                  full;
   logic                  empty;

   int checks;
   int errors;

   fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_pc    (enq_pc),
      .enq_instr (enq_instr),
      .deq_valid (deq_valid),
      .deq_ready (deq_ready),
      .deq_pc    (deq_pc),
      .deq_instr (deq_instr),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are settled and inputs may be changed on return.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_count"},     64'(count),     64'd0);
      check({tag, "_empty"},     64'(empty),     64'd1);
      check({tag, "_full"},      64'(full),      64'd0);
      check({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
      check({tag, "_enq_ready"}, 64'(enq_ready), 64'd1);
      check({tag, "_deq_pc"},    deq_pc,         64'd0);
      check({tag, "_deq_instr"}, 64'(deq_instr), 64'd0);
   endtask

   initial begin
      logic [63:0] base;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_pc    = 64'd0;
      enq_instr = 32'd0;
      deq_ready = 1'b0;

      // Reset then idle
      #3;
      check_idle("in_reset");
      step();
      step();
      rst = 1'b0;
      step();
      check_idle("after_reset");

      // Fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         enq_valid = 1'b1;
         enq_pc    = 64'h8000_0000 + 64'(4 * i);
         enq_instr = 32'h0000_0013 + 32'(i);
         step();
         check("fill_count", 64'(count), 64'(i + 1));
      end
      check("fill_full",      64'(full),      64'd1);
      check("fill_enq_ready", 64'(enq_ready), 64'd0);
      check("fill_head_pc",   deq_pc,         64'h8000_0000);
      enq_pc    = 64'h8000_0010;
      enq_instr = 32'h0000_0017;
      step();
      check("fifth_enq_count", 64'(count), 64'd4);
      enq_valid = 1'b0;

      // Drain in order
      deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 64'(deq_valid), 64'd1);
         check("drain_pc",    deq_pc,         64'h8000_0000 + 64'(4 * i));
         check("drain_instr", 64'(deq_instr), 64'h0000_0013 + 64'(i));
         step();
      end
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_pc0",   deq_pc,     64'd0);
      deq_ready = 1'b0;

      // Streaming across pointer wraps
      base      = 64'h0000_1000;
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         enq_pc    = base + 64'(4 * k);
         enq_instr = 32'hA000_0000 + 32'(k);
         if (k > 0) begin
            check("stream_pc",    deq_pc,         base + 64'(4 * (k - 1)));
            check("stream_instr", 64'(deq_instr), 64'hA000_0000 + 64'(k - 1));
         end
         step();
         check("stream_count", 64'(count), 64'd1);
      end
      enq_valid = 1'b0;
      check("stream_last_pc", deq_pc, base + 64'd36);
      step();
      check("stream_empty", 64'(empty), 64'd1);
      deq_ready = 1'b0;

      // Flush with a simultaneous enqueue
      enq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         enq_pc    = 64'h0000_2000 + 64'(4 * i);
         enq_instr = 32'hB000_0000 + 32'(i);
         step();
      end
      check("preflush_count", 64'(count), 64'd3);
      flush     = 1'b1;
      enq_pc    = 64'h8000_0100;
      enq_instr = 32'hDEAD_0001;
      deq_ready = 1'b1;
      step();
      flush     = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      check_idle("post_flush");
      enq_valid = 1'b1;
      enq_pc    = 64'h8000_0200;
      enq_instr = 32'hBEEF_0002;
      step();
      enq_valid = 1'b0;
      check("after_flush_pc",    deq_pc,         64'h8000_0200);
      check("after_flush_instr", 64'(deq_instr), 64'hBEEF_0002);
      check("after_flush_count", 64'(count),     64'd1);

      // Flush held several cycles keeps the queue empty while fetch keeps offering
      flush     = 1'b1;
      enq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         enq_pc = 64'h8000_0300 + 64'(4 * i);
         step();
         check("hold_flush_empty", 64'(empty),     64'd1);
         check("hold_flush_ready", 64'(enq_ready), 64'd1);
      end
      flush     = 1'b0;
      enq_valid = 1'b0;

      // Full with dequeue in the same cycle: no pass-through
      enq_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         enq_pc    = 64'h0000_3000 + 64'(4 * i);
         enq_instr = 32'hC000_0000 + 32'(i);
         step();
      end
      check("full2_full", 64'(full), 64'd1);
      enq_pc    = 64'h0000_3010;
      enq_instr = 32'hC000_0004;
      deq_ready = 1'b1;
      check("full_deq_enq_ready", 64'(enq_ready), 64'd0);
      step();
      check("full_deq_count", 64'(count), 64'd3);
      check("full_deq_head",  deq_pc,      64'h0000_3004);
      deq_ready = 1'b0;
      step();
      enq_valid = 1'b0;
      check("late_enq_count", 64'(count), 64'd4);
      deq_ready = 1'b1;
      step();
      step();
      deq_ready = 1'b0;
      check("pre_rst_count", 64'(count), 64'd2);
      check("pre_rst_head",  deq_pc,      64'h0000_300C);

      // Asynchronous reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      check_idle("async_rst");
      step();
      rst = 1'b0;
      step();
      check_idle("after_async_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
